// File: rtl/int_issue_queue_if.sv
// Dispatch, CDB and issue signal bundle for int_issue_queue.
// master = dispatch/CDB/ALU side, slave = the queue.
interface int_issue_queue_if #(
    parameter int TAG_W = 6
);
    logic             int_queue_en;
    logic [31:0]      disp_rs1_data;
    logic [31:0]      disp_rs2_data;
    logic [TAG_W-1:0] disp_rs1_tag;
    logic [TAG_W-1:0] disp_rs2_tag;
    logic             disp_rs1_rdy;
    logic             disp_rs2_rdy;
    logic [TAG_W-1:0] disp_rd_tag;
    logic             disp_imm;
    logic [31:0]      disp_pc;
    logic [6:0]       opcode;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             queue_full;
    logic             iss_valid;
    logic             iss_ready;
    logic [31:0]      iss_rs1;
    logic [31:0]      iss_rs2;
    logic [31:0]      iss_pc;
    logic [TAG_W-1:0] iss_rd_tag;
    logic [6:0]       iss_opcode;
    logic [6:0]       iss_funct7;
    logic [2:0]       iss_funct3;
    logic             iss_imm;

    modport master (
        output int_queue_en, disp_rs1_data, disp_rs2_data, disp_rs1_tag, disp_rs2_tag,
               disp_rs1_rdy, disp_rs2_rdy, disp_rd_tag, disp_imm, disp_pc, opcode,
               funct7, funct3, cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  queue_full, iss_valid, iss_rs1, iss_rs2, iss_pc, iss_rd_tag,
               iss_opcode, iss_funct7, iss_funct3, iss_imm
    );

    modport slave (
        input  int_queue_en, disp_rs1_data, disp_rs2_data, disp_rs1_tag, disp_rs2_tag,
               disp_rs1_rdy, disp_rs2_rdy, disp_rd_tag, disp_imm, disp_pc, opcode,
               funct7, funct3, cdb_valid, cdb_tag, cdb_data, iss_ready,
        output queue_full, iss_valid, iss_rs1, iss_rs2, iss_pc, iss_rd_tag,
               iss_opcode, iss_funct7, iss_funct3, iss_imm
    );
endinterface

// File: rtl/int_issue_queue.sv
// Compacting integer issue queue: CDB wakeup, oldest-ready-first issue, shift-down on removal.
// Optional macro INT_ISSUE_QUEUE_CDB_BYPASS_EN captures a same-edge CDB broadcast into the dispatched entry.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic clk,
    input  logic rst,
    int_issue_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]      rs1_data;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs1_rdy;
        logic [31:0]      rs2_data;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rd_tag;
        logic             imm;
        logic [31:0]      pc;
        logic [6:0]       opcode;
        logic [6:0]       funct7;
        logic [2:0]       funct3;
    } entry_t;

    function automatic entry_t capture(input entry_t e, input logic cv,
                                       input logic [TAG_W-1:0] ct, input logic [31:0] cd);
        entry_t r;
        r = e;
        if (cv && !r.rs1_rdy && (r.rs1_tag == ct)) begin
            r.rs1_rdy  = 1'b1;
            r.rs1_data = cd;
        end
        if (cv && !r.rs2_rdy && (r.rs2_tag == ct)) begin
            r.rs2_rdy  = 1'b1;
            r.rs2_data = cd;
        end
        return r;
    endfunction

    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [CNT_W-1:0] count_reg, count_next;
    entry_t           entry_reg  [DEPTH];
    entry_t           entry_next [DEPTH];
    entry_t           cap        [DEPTH];
    logic [DEPTH-1:0] issuable;
    logic [IDX_W-1:0] sel_idx;
    entry_t           sel_entry;
    entry_t           disp_raw;
    entry_t           disp_entry;
    logic             queue_full;
    logic             iss_any;
    logic             issue_fire;
    logic             disp_fire;
    logic [CNT_W-1:0] wr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign issuable[gi] = valid_reg[gi] && entry_reg[gi].rs1_rdy && entry_reg[gi].rs2_rdy;
            // Wakeup is applied before shifting so a moving entry never misses a broadcast.
            assign cap[gi] = capture(entry_reg[gi], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
    endgenerate

    // Lowest issuable index wins: the loop runs downward so the last hit is the oldest.
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (issuable[i]) sel_idx = IDX_W'(i);
        end
    end

    assign queue_full = (count_reg == CNT_W'(DEPTH));
    assign iss_any    = |issuable;
    assign issue_fire = iss_any && bus.iss_ready;
    assign disp_fire  = bus.int_queue_en && !queue_full;
    assign wr_idx     = count_reg - CNT_W'(issue_fire);

    always_comb begin
        disp_raw          = '0;
        disp_raw.rs1_data = bus.disp_rs1_data;
        disp_raw.rs1_tag  = bus.disp_rs1_tag;
        disp_raw.rs1_rdy  = bus.disp_rs1_rdy;
        disp_raw.rs2_data = bus.disp_rs2_data;
        disp_raw.rs2_tag  = bus.disp_rs2_tag;
        disp_raw.rs2_rdy  = bus.disp_rs2_rdy | bus.disp_imm;
        disp_raw.rd_tag   = bus.disp_rd_tag;
        disp_raw.imm      = bus.disp_imm;
        disp_raw.pc       = bus.disp_pc;
        disp_raw.opcode   = bus.opcode;
        disp_raw.funct7   = bus.funct7;
        disp_raw.funct3   = bus.funct3;
    end

`ifdef INT_ISSUE_QUEUE_CDB_BYPASS_EN
    assign disp_entry = capture(disp_raw, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`else
    assign disp_entry = disp_raw;
`endif

    always_comb begin
        valid_next = valid_reg;
        for (int i = 0; i < DEPTH; i++) entry_next[i] = cap[i];
        if (issue_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    valid_next[i] = valid_reg[i+1];
                    entry_next[i] = cap[i+1];
                end
            end
            valid_next[DEPTH-1] = 1'b0;
        end
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    valid_next[i] = 1'b1;
                    entry_next[i] = disp_entry;
                end
            end
        end
        count_next = count_reg + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) entry_reg[i] <= entry_next[i];
    end

    // Payload is forced to zero when nothing issues, so outputs are clean in reset.
    assign sel_entry      = entry_reg[sel_idx];
    assign bus.queue_full = queue_full;
    assign bus.iss_valid  = iss_any;
    assign bus.iss_rs1    = iss_any ? sel_entry.rs1_data : '0;
    assign bus.iss_rs2    = iss_any ? sel_entry.rs2_data : '0;
    assign bus.iss_pc     = iss_any ? sel_entry.pc       : '0;
    assign bus.iss_rd_tag = iss_any ? sel_entry.rd_tag   : '0;
    assign bus.iss_opcode = iss_any ? sel_entry.opcode   : '0;
    assign bus.iss_funct7 = iss_any ? sel_entry.funct7   : '0;
    assign bus.iss_funct3 = iss_any ? sel_entry.funct3   : '0;
    assign bus.iss_imm    = iss_any ? sel_entry.imm      : 1'b0;
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: a vector table plus hand sequences for full, compaction,
// CDB bypass (INT_ISSUE_QUEUE_CDB_BYPASS_EN) and asynchronous reset.
module tb_int_issue_queue;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   nstep    = 0;

    int_issue_queue_if #(.TAG_W(6)) bus ();

    int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [5:0]  rd;
        logic        r1_rdy;
        logic [5:0]  r1_tag;
        logic [31:0] r1_data;
        logic        r2_rdy;
        logic [5:0]  r2_tag;
        logic [31:0] r2_data;
        logic        imm;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        ir;
        logic        ev;
        logic [5:0]  erd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eimm;
        logic        ef;
    } vec_t;

    function automatic vec_t mk(
        input logic en, input logic [5:0] rd,
        input logic r1_rdy, input logic [5:0] r1_tag, input logic [31:0] r1_data,
        input logic r2_rdy, input logic [5:0] r2_tag, input logic [31:0] r2_data,
        input logic imm, input logic cv, input logic [5:0] ct, input logic [31:0] cd,
        input logic ir, input logic ev, input logic [5:0] erd,
        input logic [31:0] e1, input logic [31:0] e2, input logic eimm, input logic ef);
        vec_t v;
        v.en = en; v.rd = rd; v.r1_rdy = r1_rdy; v.r1_tag = r1_tag; v.r1_data = r1_data;
        v.r2_rdy = r2_rdy; v.r2_tag = r2_tag; v.r2_data = r2_data; v.imm = imm;
        v.cv = cv; v.ct = ct; v.cd = cd; v.ir = ir; v.ev = ev; v.erd = erd;
        v.e1 = e1; v.e2 = e2; v.eimm = eimm; v.ef = ef;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.int_queue_en  = v.en;
        bus.disp_rd_tag   = v.rd;
        bus.disp_rs1_rdy  = v.r1_rdy;
        bus.disp_rs1_tag  = v.r1_tag;
        bus.disp_rs1_data = v.r1_data;
        bus.disp_rs2_rdy  = v.r2_rdy;
        bus.disp_rs2_tag  = v.r2_tag;
        bus.disp_rs2_data = v.r2_data;
        bus.disp_imm      = v.imm;
        bus.disp_pc       = 32'h1000 + {24'd0, v.rd, 2'b00};
        bus.opcode        = 7'h33;
        bus.funct7        = {1'b0, v.rd};
        bus.funct3        = v.rd[2:0];
        bus.cdb_valid     = v.cv;
        bus.cdb_tag       = v.ct;
        bus.cdb_data      = v.cd;
        bus.iss_ready     = v.ir;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Outputs are checked after driving this cycle's inputs, i.e. they reflect state before the edge.
    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        #1;
        nstep++;
        chk({name, ".iss_valid"}, 32'(bus.iss_valid), 32'(v.ev));
        chk({name, ".queue_full"}, 32'(bus.queue_full), 32'(v.ef));
        if (v.ev) begin
            chk({name, ".iss_rd_tag"}, 32'(bus.iss_rd_tag), 32'(v.erd));
            chk({name, ".iss_rs1"}, bus.iss_rs1, v.e1);
            chk({name, ".iss_rs2"}, bus.iss_rs2, v.e2);
            chk({name, ".iss_pc"}, bus.iss_pc, 32'h1000 + {24'd0, v.erd, 2'b00});
            chk({name, ".iss_funct3"}, 32'(bus.iss_funct3), 32'(v.erd[2:0]));
            chk({name, ".iss_funct7"}, 32'(bus.iss_funct7), {26'd0, v.erd});
            chk({name, ".iss_opcode"}, 32'(bus.iss_opcode), 32'h33);
            chk({name, ".iss_imm"}, 32'(bus.iss_imm), 32'(v.eimm));
        end
        $display("step %0d %s en=%0b rd=%0d iss_valid=%0b iss_rd=%0d full=%0b",
                 nstep, name, v.en, v.rd, bus.iss_valid, bus.iss_rd_tag, bus.queue_full);
    endtask

    // Both-ready dispatch with data rs1=rd, rs2=rd+0x100.
    task automatic disp_rdy(input logic [5:0] rd, input logic ir, input logic ev,
                            input logic [5:0] erd, input logic ef, input string name);
        step(mk(1'b1, rd, 1'b1, 6'd0, 32'(rd), 1'b1, 6'd0, 32'(rd) + 32'h100, 1'b0,
                1'b0, 6'd0, 32'd0, ir, ev, erd, 32'(erd), 32'(erd) + 32'h100, 1'b0, ef), name);
    endtask

    task automatic idle(input logic ir, input logic ev, input logic [5:0] erd,
                        input logic ef, input string name);
        step(mk(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0,
                1'b0, 6'd0, 32'd0, ir, ev, erd, 32'(erd), 32'(erd) + 32'h100, 1'b0, ef), name);
    endtask

    vec_t tbl [15];
    vec_t z;

    initial begin
        z = mk(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0,
               1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        //            en    rd     r1rdy r1tag  r1data      r2rdy r2tag  r2data    imm   cv    ct     cd           ir    ev    erd     e1           e2          eimm  ef
        tbl[0]  = mk(1'b1, 6'd5,  1'b1, 6'd0, 32'h11,   1'b1, 6'd0, 32'h22, 1'b0, 1'b0, 6'd0, 32'h0,    1'b0, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b1, 6'd5,  32'h11,   32'h22, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 6'd10, 1'b0, 6'd3, 32'hDEAD, 1'b1, 6'd0, 32'h22, 1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 6'd11, 1'b1, 6'd0, 32'h33,   1'b1, 6'd0, 32'h44, 1'b0, 1'b0, 6'd0, 32'h0,    1'b0, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b1, 6'd11, 32'h33,   32'h44, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 6'd3, 32'h1234, 1'b1, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b1, 6'd10, 32'h1234, 32'h22, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 6'd12, 1'b1, 6'd0, 32'h55,   1'b0, 6'd9, 32'h66, 1'b1, 1'b0, 6'd0, 32'h0,    1'b0, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b1, 6'd12, 32'h55,   32'h66, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 6'd20, 1'b1, 6'd0, 32'h1,    1'b1, 6'd0, 32'h2,  1'b0, 1'b0, 6'd0, 32'h0,    1'b0, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);
        tbl[11] = mk(1'b1, 6'd21, 1'b1, 6'd7, 32'h3,    1'b0, 6'd7, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b0, 1'b1, 6'd20, 32'h1,    32'h2,  1'b0, 1'b0);
        tbl[12] = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b1, 6'd7, 32'h77,   1'b1, 1'b1, 6'd20, 32'h1,    32'h2,  1'b0, 1'b0);
        tbl[13] = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b1, 6'd21, 32'h3,    32'h77, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 6'd0,  1'b0, 6'd0, 32'h0,    1'b0, 6'd0, 32'h0,  1'b0, 1'b0, 6'd0, 32'h0,    1'b1, 1'b0, 6'd0,  32'h0,    32'h0,  1'b0, 1'b0);

        rst = 1'b0;
        drive(z);
        repeat (2) @(negedge clk);
        #1;
        chk("reset.iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("reset.queue_full", 32'(bus.queue_full), 32'd0);
        chk("reset.iss_rd_tag", 32'(bus.iss_rd_tag), 32'd0);
        chk("reset.iss_rs1", bus.iss_rs1, 32'd0);
        $display("step reset outputs iss_valid=%0b full=%0b", bus.iss_valid, bus.queue_full);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Fill to full, drop a fifth dispatch, then drain in age order.
        disp_rdy(6'd30, 1'b0, 1'b0, 6'd0,  1'b0, "fill0");
        disp_rdy(6'd31, 1'b0, 1'b1, 6'd30, 1'b0, "fill1");
        disp_rdy(6'd32, 1'b0, 1'b1, 6'd30, 1'b0, "fill2");
        disp_rdy(6'd33, 1'b0, 1'b1, 6'd30, 1'b0, "fill3");
        disp_rdy(6'd34, 1'b0, 1'b1, 6'd30, 1'b1, "drop5th");
        idle(1'b1, 1'b1, 6'd30, 1'b1, "full_issue");
        idle(1'b1, 1'b1, 6'd31, 1'b0, "notfull");
        idle(1'b1, 1'b1, 6'd32, 1'b0, "drain32");
        idle(1'b1, 1'b1, 6'd33, 1'b0, "drain33");
        idle(1'b1, 1'b0, 6'd0,  1'b0, "dropped_gone");

        // Issue from the middle: full blocks dispatch; at count=3 issue+dispatch keeps count.
        step(mk(1'b1, 6'd40, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'h128, 1'b0, 1'b0, 6'd0, 32'd0,
                1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0), "mid_e40");
        disp_rdy(6'd41, 1'b0, 1'b0, 6'd0,  1'b0, "mid_e41");
        disp_rdy(6'd42, 1'b0, 1'b1, 6'd41, 1'b0, "mid_e42");
        disp_rdy(6'd43, 1'b0, 1'b1, 6'd41, 1'b0, "mid_e43");
        disp_rdy(6'd44, 1'b1, 1'b1, 6'd41, 1'b1, "full_iss_disp");
        disp_rdy(6'd45, 1'b1, 1'b1, 6'd42, 1'b0, "cnt3_iss_disp");
        disp_rdy(6'd46, 1'b0, 1'b1, 6'd43, 1'b0, "cnt3_plus1");
        idle(1'b1, 1'b1, 6'd43, 1'b1, "order43");
        idle(1'b1, 1'b1, 6'd45, 1'b0, "order45");
        idle(1'b1, 1'b1, 6'd46, 1'b0, "order46");
        step(mk(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 6'd12, 32'd40,
                1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0), "wake40");
        idle(1'b1, 1'b1, 6'd40, 1'b0, "issue40");
        idle(1'b1, 1'b0, 6'd0,  1'b0, "empty2");

        // Dispatch meets a same-edge broadcast of its rs2 tag.
        step(mk(1'b1, 6'd50, 1'b1, 6'd0, 32'd50, 1'b0, 6'd7, 32'd0, 1'b0, 1'b1, 6'd7, 32'hBEEF,
                1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0), "byp_disp");
`ifdef INT_ISSUE_QUEUE_CDB_BYPASS_EN
        step(mk(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0,
                1'b1, 1'b1, 6'd50, 32'd50, 32'hBEEF, 1'b0, 1'b0), "byp_issue");
        idle(1'b1, 1'b0, 6'd0, 1'b0, "byp_empty");
`else
        idle(1'b1, 1'b0, 6'd0, 1'b0, "nobyp_wait0");
        idle(1'b1, 1'b0, 6'd0, 1'b0, "nobyp_wait1");
        step(mk(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 6'd7, 32'hCAFE,
                1'b1, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0), "nobyp_wake");
        step(mk(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0,
                1'b1, 1'b1, 6'd50, 32'd50, 32'hCAFE, 1'b0, 1'b0), "nobyp_issue");
`endif

        // Asynchronous reset with three entries held.
        disp_rdy(6'd60, 1'b0, 1'b0, 6'd0,  1'b0, "rst_e60");
        disp_rdy(6'd61, 1'b0, 1'b1, 6'd60, 1'b0, "rst_e61");
        disp_rdy(6'd62, 1'b0, 1'b1, 6'd60, 1'b0, "rst_e62");
        @(negedge clk);
        drive(z);
        #1;
        chk("prerst.iss_valid", 32'(bus.iss_valid), 32'd1);
        chk("prerst.iss_rd_tag", 32'(bus.iss_rd_tag), 32'd60);
        rst = 1'b0;
        #1;
        chk("async_rst.iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("async_rst.queue_full", 32'(bus.queue_full), 32'd0);
        chk("async_rst.iss_rd_tag", 32'(bus.iss_rd_tag), 32'd0);
        chk("async_rst.iss_rs1", bus.iss_rs1, 32'd0);
        chk("async_rst.iss_pc", bus.iss_pc, 32'd0);
        $display("step async reset iss_valid=%0b full=%0b", bus.iss_valid, bus.queue_full);
        @(negedge clk);
        rst = 1'b1;
        idle(1'b1, 1'b0, 6'd0, 1'b0, "post_rst_empty");
        disp_rdy(6'd63, 1'b0, 1'b0, 6'd0, 1'b0, "post_rst_disp");
        idle(1'b1, 1'b1, 6'd63, 1'b0, "post_rst_issue");
        idle(1'b1, 1'b0, 6'd0,  1'b0, "post_rst_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
